controle_multiciclo: RTL and testbench
======================================

Name: controle_multiciclo

Overview:
- Moore FSM main controller for the multi-cycle RV32 subset datapath: add/sub/xor/srl (R-type), addi, lw, sw, beq.
- Sequences fetch/decode/execute/memory/writeback.
- Drives the 2-bit ALU-op consumed by the existing ALU-control decoder, plus all datapath mux selects and write enables.
- Stalls on a memory-ready handshake.

Parameters:
- OPC_W, 7, opcode width.
- TRAP_STICKY, 1, 1 = illegal opcode parks FSM in TRAP until reset; 0 = TRAP returns to FETCH after one cycle.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high
- opcode  in  7  instruction[6:0] from the instruction register (valid from DECODE on)
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes the current read/write this cycle
- pc_write  out  1  unconditional PC load
- pc_write_cond  out  1  PC load qualified by zero (beq)
- pc_source  out  1  0 = ALU result, 1 = ALUOut register
- ir_write  out  1  load instruction register
- old_pc_write  out  1  capture PC before increment
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- i_or_d  out  1  0 = PC address, 1 = ALUOut address
- alu_src_a  out  2  00 PC, 01 rs1, 10 old PC
- alu_src_b  out  2  00 rs2, 01 const 4, 10 immediate
- alu_op  out  2  00 add, 01 sub, 10 funct-decoded
- reg_write  out  1  register-file write enable
- mem_to_reg  out  1  0 = ALUOut, 1 = memory data register
- instr_done  out  1  one-cycle pulse in an instruction's final state
- illegal  out  1  unsupported opcode detected

Behaviour:
- States: FETCH, DECODE, EXEC_R, EXEC_I, MEM_ADDR, MEM_RD, MEM_WR, WB_ALU, WB_MEM, BRANCH, TRAP. Outputs are a pure function of state; all strobes not listed for a state are 0.
- Reset: on a clk edge with reset=1, state<=FETCH and illegal<=0. While reset=1, all strobes are forced to 0 combinationally. Reset mid-instruction aborts it with no partial writes after that edge.
- FETCH:
  - Outputs: mem_read=1, i_or_d=0, alu_src_a=00, alu_src_b=01, alu_op=00.
  - mem_ready=0: hold FETCH; ir_write, pc_write, old_pc_write stay 0.
  - mem_ready=1: ir_write=1, pc_write=1, old_pc_write=1, pc_source=0; next state DECODE.
- DECODE: alu_src_a=10, alu_src_b=10, alu_op=00 (branch target into ALUOut). Next state by opcode:
  - 0110011 -> EXEC_R
  - 0010011 -> EXEC_I
  - 0000011 or 0100011 -> MEM_ADDR
  - 1100011 -> BRANCH
  - else -> TRAP
- EXEC_R: alu_src_a=01, alu_src_b=00, alu_op=10 -> WB_ALU.
- EXEC_I: alu_src_a=01, alu_src_b=10, alu_op=00 -> WB_ALU.
- WB_ALU: reg_write=1, mem_to_reg=0, instr_done=1 -> FETCH.
- MEM_ADDR: alu_src_a=01, alu_src_b=10, alu_op=00. Next: load -> MEM_RD, store -> MEM_WR. Opcode is re-sampled here; IR is stable.
- MEM_RD: mem_read=1, i_or_d=1. Hold until mem_ready=1, then -> WB_MEM.
- WB_MEM: reg_write=1, mem_to_reg=1, instr_done=1 -> FETCH.
- MEM_WR: mem_write=1, i_or_d=1. Hold until mem_ready=1; in the ready cycle instr_done=1 -> FETCH.
- BRANCH: alu_src_a=01, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=1, instr_done=1 -> FETCH. funct3 is ignored; every branch is treated as beq.
- TRAP: illegal=1 (registered, set on DECODE->TRAP). If TRAP_STICKY=1, hold until reset; else instr_done=1 and -> FETCH, with illegal held until reset.
- Latency with mem_ready tied to 1:
  - R-type / addi: 4 cycles
  - lw: 5 cycles
  - sw: 4 cycles
  - beq: 3 cycles
  - each mem_ready=0 cycle in FETCH/MEM_RD/MEM_WR adds 1.
- mem_read and mem_write are never asserted together. reg_write and the PC writes never coincide with a stall.

Decomposition:
- Shared package (pacote_controle):
  - state enum
  - opcode constants OPC_R, OPC_I, OPC_LOAD, OPC_STORE, OPC_BRANCH
  - alu_op constants ALUOP_ADD=00, ALUOP_SUB=01, ALUOP_FUNCT=10
  - mux-select encodings
- Optional sub-module decodificador_opcode: opcode -> {is_r, is_i, is_load, is_store, is_branch, is_illegal}, used by DECODE and MEM_ADDR.
- FSM register, next-state logic and output decode stay in controle_multiciclo.

Test Plan:
- Reset held 2 cycles, then released with mem_ready=1 and opcode 0110011 -> DECODE, EXEC_R (alu_op=10), WB_ALU (reg_write=1, instr_done=1), then back to FETCH; 4 cycles total.
- lw (0000011) with mem_ready low for 3 cycles in MEM_RD -> mem_read=1 and i_or_d=1 held 4 cycles; WB_MEM has mem_to_reg=1, reg_write=1; total 8 cycles.
- sw (0100011), mem_ready=1 -> mem_write=1 for exactly 1 cycle; reg_write never asserted; instr_done in the MEM_WR cycle.
- beq (1100011) with zero=1, then again with zero=0 -> pc_write_cond=1, pc_source=1, alu_op=01 in BRANCH both times; 3 cycles each.
- Opcode 1111111 with TRAP_STICKY=1 -> illegal=1 from the cycle after DECODE and held; no strobes for 10 cycles; reset clears to FETCH with illegal=0.
- Reset asserted in the MEM_RD stall cycle -> all strobes 0 that cycle; FETCH next cycle; no reg_write ever occurs.

Source files
------------

// File: rtl/controle_multiciclo_pkg.sv
// Shared types and encodings for the multi-cycle RV32 subset main controller.
package controle_multiciclo_pkg;

  typedef enum logic [3:0] {
    ST_FETCH,
    ST_DECODE,
    ST_EXEC_R,
    ST_EXEC_I,
    ST_MEM_ADDR,
    ST_MEM_RD,
    ST_MEM_WR,
    ST_WB_ALU,
    ST_WB_MEM,
    ST_BRANCH,
    ST_TRAP
  } estado_t;

  // Major opcodes of the supported subset
  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_I      = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  // ALU-op handed to the ALU-control decoder
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // ALU operand A select
  localparam logic [1:0] ASRC_PC    = 2'b00;
  localparam logic [1:0] ASRC_RS1   = 2'b01;
  localparam logic [1:0] ASRC_OLDPC = 2'b10;

  // ALU operand B select
  localparam logic [1:0] BSRC_RS2  = 2'b00;
  localparam logic [1:0] BSRC_FOUR = 2'b01;
  localparam logic [1:0] BSRC_IMM  = 2'b10;

  // Single-bit mux selects
  localparam logic PCSRC_ALU    = 1'b0;
  localparam logic PCSRC_ALUOUT = 1'b1;
  localparam logic IORD_PC      = 1'b0;
  localparam logic IORD_ALUOUT  = 1'b1;
  localparam logic MTR_ALUOUT   = 1'b0;
  localparam logic MTR_MDR      = 1'b1;

  // Every datapath strobe/select the controller drives, except the sticky illegal flag
  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       pc_source;
    logic       ir_write;
    logic       old_pc_write;
    logic       mem_read;
    logic       mem_write;
    logic       i_or_d;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       reg_write;
    logic       mem_to_reg;
    logic       instr_done;
  } saidas_t;

endpackage

// File: rtl/controle_multiciclo_if.sv
// Controller <-> datapath bundle: instruction/status inputs and all control strobes.
interface controle_multiciclo_if #(
  parameter int OPC_W = 7
);
  logic [OPC_W-1:0] opcode;
  logic             zero;
  logic             mem_ready;
  logic             pc_write;
  logic             pc_write_cond;
  logic             pc_source;
  logic             ir_write;
  logic             old_pc_write;
  logic             mem_read;
  logic             mem_write;
  logic             i_or_d;
  logic [1:0]       alu_src_a;
  logic [1:0]       alu_src_b;
  logic [1:0]       alu_op;
  logic             reg_write;
  logic             mem_to_reg;
  logic             instr_done;
  logic             illegal;

  modport master (
    input  opcode, zero, mem_ready,
    output pc_write, pc_write_cond, pc_source, ir_write, old_pc_write,
           mem_read, mem_write, i_or_d, alu_src_a, alu_src_b, alu_op,
           reg_write, mem_to_reg, instr_done, illegal
  );

  modport slave (
    output opcode, zero, mem_ready,
    input  pc_write, pc_write_cond, pc_source, ir_write, old_pc_write,
           mem_read, mem_write, i_or_d, alu_src_a, alu_src_b, alu_op,
           reg_write, mem_to_reg, instr_done, illegal
  );
endinterface

// File: rtl/controle_multiciclo_decodificador.sv
// Opcode classifier shared by the DECODE and MEM_ADDR transitions.
module controle_multiciclo_decodificador
  import controle_multiciclo_pkg::*;
#(
  parameter int OPC_W = 7
) (
  input  logic [OPC_W-1:0] opcode,
  output logic             is_r,
  output logic             is_i,
  output logic             is_load,
  output logic             is_store,
  output logic             is_branch,
  output logic             is_illegal
);

  // Pure compare against the supported major opcodes
  always_comb begin
    is_r       = (opcode == OPC_W'(OPC_R));
    is_i       = (opcode == OPC_W'(OPC_I));
    is_load    = (opcode == OPC_W'(OPC_LOAD));
    is_store   = (opcode == OPC_W'(OPC_STORE));
    is_branch  = (opcode == OPC_W'(OPC_BRANCH));
    is_illegal = !(is_r || is_i || is_load || is_store || is_branch);
  end

endmodule

// File: rtl/controle_multiciclo.sv
// Moore main controller for the multi-cycle RV32 subset datapath
// (add/sub/xor/srl, addi, lw, sw, beq) with memory-ready stalls.
module controle_multiciclo
  import controle_multiciclo_pkg::*;
#(
  parameter int OPC_W       = 7,
  parameter bit TRAP_STICKY = 1'b1
) (
  input logic                  clk,
  input logic                  reset,
  controle_multiciclo_if.master bus
);

  estado_t estado, prox;
  saidas_t s;
  logic    ilegal_r;
  logic    is_r, is_i, is_load, is_store, is_branch, is_illegal;
  logic    unused_zero;

  // The zero flag qualifies pc_write_cond inside the datapath, not here
  assign unused_zero = bus.zero;

  controle_multiciclo_decodificador #(.OPC_W(OPC_W)) u_dec (
    .opcode    (bus.opcode),
    .is_r      (is_r),
    .is_i      (is_i),
    .is_load   (is_load),
    .is_store  (is_store),
    .is_branch (is_branch),
    .is_illegal(is_illegal)
  );

  // State register and sticky illegal flag (set on any entry into TRAP)
  always_ff @(posedge clk) begin
    if (reset) begin
      estado   <= ST_FETCH;
      ilegal_r <= 1'b0;
    end else begin
      estado <= prox;
      if (prox == ST_TRAP) ilegal_r <= 1'b1;
    end
  end

  // Next-state and per-state output decode; reset blanks every strobe
  always_comb begin
    prox = estado;
    s    = '0;
    unique case (estado)
      ST_FETCH: begin
        s.mem_read  = 1'b1;
        s.i_or_d    = IORD_PC;
        s.alu_src_a = ASRC_PC;
        s.alu_src_b = BSRC_FOUR;
        s.alu_op    = ALUOP_ADD;
        if (bus.mem_ready) begin
          s.ir_write     = 1'b1;
          s.pc_write     = 1'b1;
          s.old_pc_write = 1'b1;
          s.pc_source    = PCSRC_ALU;
          prox           = ST_DECODE;
        end
      end
      ST_DECODE: begin
        // Branch target old_pc + imm parked in ALUOut for a possible BRANCH
        s.alu_src_a = ASRC_OLDPC;
        s.alu_src_b = BSRC_IMM;
        s.alu_op    = ALUOP_ADD;
        if (is_illegal)     prox = ST_TRAP;
        else if (is_r)      prox = ST_EXEC_R;
        else if (is_i)      prox = ST_EXEC_I;
        else if (is_branch) prox = ST_BRANCH;
        else                prox = ST_MEM_ADDR;
      end
      ST_EXEC_R: begin
        s.alu_src_a = ASRC_RS1;
        s.alu_src_b = BSRC_RS2;
        s.alu_op    = ALUOP_FUNCT;
        prox        = ST_WB_ALU;
      end
      ST_EXEC_I: begin
        s.alu_src_a = ASRC_RS1;
        s.alu_src_b = BSRC_IMM;
        s.alu_op    = ALUOP_ADD;
        prox        = ST_WB_ALU;
      end
      ST_WB_ALU: begin
        s.reg_write  = 1'b1;
        s.mem_to_reg = MTR_ALUOUT;
        s.instr_done = 1'b1;
        prox         = ST_FETCH;
      end
      ST_MEM_ADDR: begin
        s.alu_src_a = ASRC_RS1;
        s.alu_src_b = BSRC_IMM;
        s.alu_op    = ALUOP_ADD;
        if (is_load)       prox = ST_MEM_RD;
        else if (is_store) prox = ST_MEM_WR;
        else               prox = ST_TRAP;
      end
      ST_MEM_RD: begin
        s.mem_read = 1'b1;
        s.i_or_d   = IORD_ALUOUT;
        if (bus.mem_ready) prox = ST_WB_MEM;
      end
      ST_WB_MEM: begin
        s.reg_write  = 1'b1;
        s.mem_to_reg = MTR_MDR;
        s.instr_done = 1'b1;
        prox         = ST_FETCH;
      end
      ST_MEM_WR: begin
        s.mem_write = 1'b1;
        s.i_or_d    = IORD_ALUOUT;
        if (bus.mem_ready) begin
          s.instr_done = 1'b1;
          prox         = ST_FETCH;
        end
      end
      ST_BRANCH: begin
        // Every branch compares as beq; funct3 is not looked at
        s.alu_src_a     = ASRC_RS1;
        s.alu_src_b     = BSRC_RS2;
        s.alu_op        = ALUOP_SUB;
        s.pc_write_cond = 1'b1;
        s.pc_source     = PCSRC_ALUOUT;
        s.instr_done    = 1'b1;
        prox            = ST_FETCH;
      end
      ST_TRAP: begin
        if (!TRAP_STICKY) begin
          s.instr_done = 1'b1;
          prox         = ST_FETCH;
        end
      end
      default: prox = ST_FETCH;
    endcase
    if (reset) s = '0;
  end

  assign bus.pc_write      = s.pc_write;
  assign bus.pc_write_cond = s.pc_write_cond;
  assign bus.pc_source     = s.pc_source;
  assign bus.ir_write      = s.ir_write;
  assign bus.old_pc_write  = s.old_pc_write;
  assign bus.mem_read      = s.mem_read;
  assign bus.mem_write     = s.mem_write;
  assign bus.i_or_d        = s.i_or_d;
  assign bus.alu_src_a     = s.alu_src_a;
  assign bus.alu_src_b     = s.alu_src_b;
  assign bus.alu_op        = s.alu_op;
  assign bus.reg_write     = s.reg_write;
  assign bus.mem_to_reg    = s.mem_to_reg;
  assign bus.instr_done    = s.instr_done;
  assign bus.illegal       = ilegal_r;

endmodule

// File: tb/tb_controle_multiciclo.sv
// Bench for controle_multiciclo: per-cycle expected strobe traces built from
// the instruction-level behaviour, directed cases followed by random programs.
module tb_controle_multiciclo;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       pc_source;
    logic       ir_write;
    logic       old_pc_write;
    logic       mem_read;
    logic       mem_write;
    logic       i_or_d;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       reg_write;
    logic       mem_to_reg;
    logic       instr_done;
    logic       illegal;
  } outs_t;

  typedef struct {
    logic       rst;
    logic       rdy;
    logic       z;
    logic [6:0] opc;
    outs_t      exp;
    string      tag;
  } cyc_t;

  logic  clk   = 1'b0;
  logic  reset = 1'b1;
  int    errors = 0;
  int    checks = 0;
  logic  ill    = 1'b0;
  cyc_t  script[$];
  outs_t got;

  controle_multiciclo_if #(.OPC_W(7)) bus ();

  controle_multiciclo #(.OPC_W(7), .TRAP_STICKY(1'b1)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  assign got = {bus.pc_write, bus.pc_write_cond, bus.pc_source, bus.ir_write,
                bus.old_pc_write, bus.mem_read, bus.mem_write, bus.i_or_d,
                bus.alu_src_a, bus.alu_src_b, bus.alu_op, bus.reg_write,
                bus.mem_to_reg, bus.instr_done, bus.illegal};

  // ---------------- reference model: expected strobes per cycle ----------------
  function automatic outs_t base();
    outs_t v = '0;
    v.illegal = ill;
    return v;
  endfunction

  function automatic outs_t v_fetch(logic rdy);
    outs_t v = base();
    v.mem_read  = 1'b1;
    v.alu_src_b = 2'b01;
    if (rdy) begin
      v.ir_write     = 1'b1;
      v.pc_write     = 1'b1;
      v.old_pc_write = 1'b1;
    end
    return v;
  endfunction

  function automatic outs_t v_alu(logic [1:0] a, logic [1:0] b, logic [1:0] op);
    outs_t v = base();
    v.alu_src_a = a;
    v.alu_src_b = b;
    v.alu_op    = op;
    return v;
  endfunction

  function automatic outs_t v_wb(logic from_mem);
    outs_t v = base();
    v.reg_write  = 1'b1;
    v.mem_to_reg = from_mem;
    v.instr_done = 1'b1;
    return v;
  endfunction

  function automatic outs_t v_mem(logic wr, logic done);
    outs_t v = base();
    v.mem_read   = !wr;
    v.mem_write  = wr;
    v.i_or_d     = 1'b1;
    v.instr_done = done;
    return v;
  endfunction

  function automatic outs_t v_branch();
    outs_t v = v_alu(2'b01, 2'b00, 2'b01);
    v.pc_write_cond = 1'b1;
    v.pc_source     = 1'b1;
    v.instr_done    = 1'b1;
    return v;
  endfunction

  task automatic push(logic rst, logic rdy, logic [6:0] opc, logic z, outs_t exp, string tag);
    cyc_t e;
    e.rst = rst; e.rdy = rdy; e.opc = opc; e.z = z; e.exp = exp; e.tag = tag;
    script.push_back(e);
  endtask

  task automatic add_fetch(int sf, logic z);
    for (int i = 0; i < sf; i++) push(1'b0, 1'b0, 7'($urandom), z, v_fetch(1'b0), "fetch_wait");
    push(1'b0, 1'b1, 7'($urandom), z, v_fetch(1'b1), "fetch");
  endtask

  // Reset cycle: strobes blank, illegal still shows its registered value until the edge
  task automatic add_reset(int n);
    for (int i = 0; i < n; i++) begin
      push(1'b1, 1'($urandom), 7'($urandom), 1'($urandom), base(), "reset");
      ill = 1'b0;
    end
  endtask

  // One whole instruction: sf fetch stalls, sm memory stalls
  task automatic add_instr(logic [6:0] opc, int sf, int sm, logic z);
    add_fetch(sf, z);
    push(1'b0, 1'($urandom), opc, z, v_alu(2'b10, 2'b10, 2'b00), "decode");
    case (opc)
      7'b0110011: begin
        push(1'b0, 1'($urandom), opc, z, v_alu(2'b01, 2'b00, 2'b10), "exec_r");
        push(1'b0, 1'($urandom), opc, z, v_wb(1'b0), "wb_alu");
      end
      7'b0010011: begin
        push(1'b0, 1'($urandom), opc, z, v_alu(2'b01, 2'b10, 2'b00), "exec_i");
        push(1'b0, 1'($urandom), opc, z, v_wb(1'b0), "wb_alu");
      end
      7'b0000011: begin
        push(1'b0, 1'($urandom), opc, z, v_alu(2'b01, 2'b10, 2'b00), "mem_addr");
        for (int i = 0; i < sm; i++) push(1'b0, 1'b0, opc, z, v_mem(1'b0, 1'b0), "mem_rd_wait");
        push(1'b0, 1'b1, opc, z, v_mem(1'b0, 1'b0), "mem_rd");
        push(1'b0, 1'($urandom), opc, z, v_wb(1'b1), "wb_mem");
      end
      7'b0100011: begin
        push(1'b0, 1'($urandom), opc, z, v_alu(2'b01, 2'b10, 2'b00), "mem_addr");
        for (int i = 0; i < sm; i++) push(1'b0, 1'b0, opc, z, v_mem(1'b1, 1'b0), "mem_wr_wait");
        push(1'b0, 1'b1, opc, z, v_mem(1'b1, 1'b1), "mem_wr");
      end
      7'b1100011: push(1'b0, 1'($urandom), opc, z, v_branch(), "branch");
      default: ill = 1'b1;
    endcase
  endtask

  task automatic run_script();
    cyc_t e;
    while (script.size() > 0) begin
      e = script.pop_front();
      reset         = e.rst;
      bus.mem_ready = e.rdy;
      bus.opcode    = e.opc;
      bus.zero      = e.z;
      @(negedge clk);
      checks++;
      assert (got === e.exp) else begin
        errors++;
        $error("FAIL %s observed=%h expected=%h", e.tag, got, e.exp);
      end
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    logic [6:0] legal [5];
    legal[0] = 7'b0110011; legal[1] = 7'b0010011; legal[2] = 7'b0000011;
    legal[3] = 7'b0100011; legal[4] = 7'b1100011;
    bus.opcode = '0; bus.zero = 1'b0; bus.mem_ready = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Reset held two cycles, then R-type with memory always ready
    add_reset(2);
    add_instr(7'b0110011, 0, 0, 1'b0);
    run_script();

    // lw with three MEM_RD stalls, then sw, then beq with zero=1 and zero=0
    add_instr(7'b0000011, 0, 3, 1'b0);
    add_instr(7'b0100011, 0, 0, 1'b0);
    add_instr(7'b1100011, 0, 0, 1'b1);
    add_instr(7'b1100011, 0, 0, 1'b0);
    run_script();

    // Random program of legal instructions with random stalls
    for (int n = 0; n < 40; n++)
      add_instr(legal[$urandom_range(0, 4)], int'($urandom_range(0, 2)),
                int'($urandom_range(0, 2)), 1'($urandom));
    run_script();

    // Reset in the middle of a MEM_RD stall aborts the load
    add_fetch(0, 1'b0);
    push(1'b0, 1'b1, 7'b0000011, 1'b0, v_alu(2'b10, 2'b10, 2'b00), "decode");
    push(1'b0, 1'b1, 7'b0000011, 1'b0, v_alu(2'b01, 2'b10, 2'b00), "mem_addr");
    push(1'b0, 1'b0, 7'b0000011, 1'b0, v_mem(1'b0, 1'b0), "mem_rd_wait");
    push(1'b1, 1'b0, 7'b0000011, 1'b0, base(), "reset_in_mem_rd");
    add_instr(7'b0010011, 1, 0, 1'b0);
    run_script();

    // Illegal opcode parks in TRAP with illegal set; reset recovers
    add_instr(7'b1111111, 0, 0, 1'b0);
    for (int i = 0; i < 10; i++) push(1'b0, 1'($urandom), 7'b1111111, 1'($urandom), base(), "trap");
    add_reset(1);
    add_instr(7'b0110011, 0, 0, 1'b0);
    run_script();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
